motion_overlay: RTL

Consumer end of the motion-mask stream. Pops one mask byte from the mask FIFO and the matching image pixel from the image FIFO. Writes an overlaid pixel to the output FIFO: the highlight value where motion is flagged, the original pixel elsewhere. Tracks the frame position and reports per-frame motion statistics, so a frame-level motion decision is available right after the mask stage.

---
 rtl/motion_overlay.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/motion_overlay.sv
// Mask/image consumer: overlays HIGHLIGHT on motion pixels and tracks per-frame motion statistics.
// Optional feature macro: MOTION_OVERLAY_STATS_EN (statistics enabled when defined).
module motion_overlay #(
    parameter int unsigned WIDTH      = 720,
    parameter int unsigned HEIGHT     = 540,
    parameter logic [7:0]  HIGHLIGHT  = 8'hFF,
    parameter int unsigned MOTION_MIN = 100,
    localparam int unsigned NPIX      = WIDTH * HEIGHT,
    localparam int unsigned CW        = $clog2(NPIX + 1)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          in_rd_en_mask,
    input  logic          in_empty_mask,
    input  logic [7:0]    in_dout_mask,
    output logic          in_rd_en_img,
    input  logic          in_empty_img,
    input  logic [7:0]    in_dout_img,
    output logic          out_wr_en,
    input  logic          out_full,
    output logic [7:0]    out_din,
    output logic          frame_done,
    output logic [CW-1:0] motion_count,
    output logic          motion_detected
);

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_WRITE = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    pix_q, pix_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic          both_avail;
    logic          last_pix;
    logic          wr_fire;

    assign both_avail = !in_empty_mask && !in_empty_img;
    assign last_pix   = (pix_cnt_q == CW'(NPIX - 1));
    assign wr_fire    = (state_q == S_WRITE) && !out_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_READ;
            pix_q     <= '0;
            pix_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READ:  if (both_avail) state_d = S_WRITE;
            S_WRITE: if (!out_full)  state_d = last_pix ? S_FRAME : S_READ;
            S_FRAME: state_d = S_READ;
            default: state_d = S_READ;
        endcase
    end

    always_comb begin
        pix_d     = pix_q;
        pix_cnt_d = pix_cnt_q;
        if (state_q == S_READ && both_avail)
            pix_d = (in_dout_mask != 8'd0) ? HIGHLIGHT : in_dout_img;
        if (wr_fire)
            pix_cnt_d = pix_cnt_q + 1'b1;
        // The pixel counter only returns to zero through the frame-boundary state.
        if (state_q == S_FRAME)
            pix_cnt_d = '0;
    end

    // Strobes are masked during reset so a pending pixel is never pushed on the reset edge.
    always_comb begin
        in_rd_en_mask = 1'b0;
        in_rd_en_img  = 1'b0;
        out_wr_en     = 1'b0;
        out_din       = 8'd0;
        frame_done    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_READ: begin
                    in_rd_en_mask = both_avail;
                    in_rd_en_img  = both_avail;
                end
                S_WRITE: begin
                    out_wr_en = !out_full;
                    out_din   = out_full ? 8'd0 : pix_q;
                end
                S_FRAME: frame_done = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MOTION_OVERLAY_STATS_EN
    logic          is_motion_q, is_motion_d;
    logic [CW-1:0] mot_cnt_q, mot_cnt_d;
    logic [CW-1:0] motion_count_q, motion_count_d;
    logic          motion_detected_q, motion_detected_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            is_motion_q       <= 1'b0;
            mot_cnt_q         <= '0;
            motion_count_q    <= '0;
            motion_detected_q <= 1'b0;
        end else begin
            is_motion_q       <= is_motion_d;
            mot_cnt_q         <= mot_cnt_d;
            motion_count_q    <= motion_count_d;
            motion_detected_q <= motion_detected_d;
        end
    end

    always_comb begin
        is_motion_d       = is_motion_q;
        mot_cnt_d         = mot_cnt_q;
        motion_count_d    = motion_count_q;
        motion_detected_d = motion_detected_q;
        if (state_q == S_READ && both_avail)
            is_motion_d = (in_dout_mask != 8'd0);
        if (wr_fire && is_motion_q && mot_cnt_q != CW'(NPIX))
            mot_cnt_d = mot_cnt_q + 1'b1;
        if (state_q == S_FRAME) begin
            motion_count_d    = mot_cnt_q;
            motion_detected_d = (32'(mot_cnt_q) > MOTION_MIN);
            mot_cnt_d         = '0;
        end
    end

    assign motion_count    = motion_count_q;
    assign motion_detected = motion_detected_q;
`else
    assign motion_count    = '0;
    assign motion_detected = 1'b0;
`endif

endmodule
